backsub_frame_arbiter: RTL and testbench
========================================

Name: backsub_frame_arbiter

Overview:
- Shares one dual_diagonal_backsub datapath among NUM_REQ parity-stream requesters.
- Grants the datapath one whole vector (exactly NUM_WORDS words) at a time, in round-robin order. The backsub's internal word counter therefore never misaligns.
- Tags every issued word with requester id, first and last flags so downstream can demultiplex the backsub output.
- Sits between the per-codeword encoder front-ends and the backsub input.

Parameters:
- WIDTH, 8, data word width; must equal the backsub WIDTH.
- NUM_WORDS, 1024, words per vector; must equal the backsub NUM_WORDS; ≥2.
- NUM_REQ, 4, number of requesters; ≥2.
- TIMEOUT, 255, watchdog stall limit in cycles; used only with the optional feature.

Ports:
- i_clock  input  1  clock.
- i_reset  input  1  reset, synchronous, active-high; shared with the backsub.
- i_req_data  input  NUM_REQ*WIDTH  requester words; requester k occupies bits [k*WIDTH +: WIDTH].
- i_req_valid  input  NUM_REQ  per-requester word valid.
- o_req_ready  output  NUM_REQ  per-requester ready; at most one bit high.
- o_bs_data  output  WIDTH  word to the backsub i_in_data.
- o_bs_valid  output  1  to the backsub i_in_valid.
- o_bs_id  output  $clog2(NUM_REQ)  requester id of the current word.
- o_bs_first  output  1  word index 0 of the vector.
- o_bs_last  output  1  word index NUM_WORDS-1.
- i_sink_ready  input  1  downstream can accept a backsub result one cycle later.
- o_busy  output  1  a vector is in progress.
- o_timeout  output  1  one-cycle pulse when a vector is padded (optional feature; tied 0 otherwise).

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter 0; round-robin pointer at requester NUM_REQ-1, so requester 0 wins first.
- States: IDLE, STREAM, and PAD (PAD exists only with the optional feature).
- IDLE:
  - o_req_ready is all 0.
  - If any i_req_valid is high, select the first requester with valid high, searching from pointer+1 upward with wrap-around. Register it as grant g; move to STREAM on the next cycle.
  - A valid that is not held is still arbitrated from its sampled value.
- STREAM:
  - o_req_ready[g] = i_sink_ready, combinationally; all other ready bits are 0.
  - A transfer occurs when i_req_valid[g] and o_req_ready[g] are both high.
  - On a transfer, the registered outputs update on the next edge:
    - o_bs_data = the requester word.
    - o_bs_valid = 1.
    - o_bs_id = g.
    - o_bs_first = (cnt==0).
    - o_bs_last = (cnt==NUM_WORDS-1).
  - Without a transfer, o_bs_valid is 0 and the other o_bs_* fields hold their previous values.
  - Latency from requester handshake to the backsub input is 1 cycle.
  - cnt increments per transfer. At the transfer with cnt==NUM_WORDS-1: cnt wraps to 0, pointer <= g, next state is IDLE.
  - This gives 1 bubble cycle minimum between vectors.
- o_busy is 1 in STREAM and PAD.
- No preemption. A vector is never interrupted by a higher-priority requester or by i_sink_ready low. Low sink ready only stalls the vector.
- i_sink_ready low: no words are issued, because the backsub has no backpressure and its output is valid exactly 1 cycle after its input.
- A requester whose valid drops mid-vector stalls the arbiter indefinitely. This only changes with the watchdog feature.
- Reset mid-vector: the arbiter returns to IDLE with cnt 0. The backsub is reset by the same i_reset, so the two stay aligned. The partial vector is discarded; the requester must restart its vector.
- Simultaneous requests: round-robin only. A requester that is granted is never granted again while any other requester is valid in IDLE.

Optional Feature:
- Macro: BACKSUB_ARB_WATCHDOG_EN.
- When defined:
  - In STREAM, a stall counter counts consecutive cycles with i_sink_ready=1 and i_req_valid[g]=0. It clears on any transfer.
  - When the counter reaches TIMEOUT, go to PAD and pulse o_timeout for 1 cycle.
  - In PAD, o_req_ready is all 0. Each cycle with i_sink_ready=1 issues a word with o_bs_data=0, id g, and the normal first/last flags, until the vector completes. Then pointer <= g and next state is IDLE.
- When undefined: no PAD state, no stall counter, o_timeout tied to 0.

Decomposition:
- Package backsub_arb_pkg holds:
  - the state enum (IDLE, STREAM, PAD);
  - a localparam function for id width ($clog2 with a minimum of 1);
  - a packed struct {data, id, first, last} for the issued word.
- One sub-module: rr_arbiter. Combinational rotating-priority pick from a request vector and pointer; outputs a one-hot and an index.

Test Plan (NUM_REQ=3, NUM_WORDS=4, TIMEOUT=8):
- Only req1 valid, words 0x11,0x22,0x33,0x44 with sink ready held → o_bs_valid is high for 4 consecutive cycles with id=1, first on 0x11, last on 0x44; the backsub outputs 0x11,0x33,0x00,0x44.
- All three requesters continuously valid → vectors are granted in order 0,1,2,0, each exactly 4 words, with a 1-cycle bubble between vectors.
- Sink ready low for 3 cycles mid-vector (after word 2) → o_req_ready and o_bs_valid are low for those 3 cycles; the vector then resumes with no lost or duplicated word and last still on word 3.
- req0 granted at mid-vector, req2 asserts valid → req2 is not granted until req0's word 3 completes.
- i_reset asserted after word 1 of req0 → all outputs 0, state IDLE; the next vector starts with first=1 and the backsub result equals a fresh XOR prefix.
- Watchdog feature: req1 valid drops after word 1 with sink ready high → o_timeout pulses after 8 cycles; words 2 and 3 are issued as 0x00 with last on word 3; the next grant goes to req2.

Source files
------------

// File: rtl/backsub_frame_arbiter_pkg.sv
// backsub_arb_pkg: state encodings and sizing helper shared by backsub_frame_arbiter and its interface.
package backsub_arb_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] PAD    = 2'd2;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/backsub_frame_arbiter_if.sv
// backsub_frame_arbiter_if: requester handshake, backsub-side word bus and status of backsub_frame_arbiter.
interface backsub_frame_arbiter_if
  import backsub_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int IW      = id_w(NUM_REQ)
);
  logic [NUM_REQ*WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic [WIDTH-1:0]         o_bs_data;
  logic                     o_bs_valid;
  logic [IW-1:0]            o_bs_id;
  logic                     o_bs_first;
  logic                     o_bs_last;
  logic                     i_sink_ready;
  logic                     o_busy;
  logic                     o_timeout;
  modport master (
    output i_req_data, i_req_valid, i_sink_ready,
    input  o_req_ready, o_bs_data, o_bs_valid, o_bs_id, o_bs_first, o_bs_last, o_busy, o_timeout
  );
  modport slave (
    input  i_req_data, i_req_valid, i_sink_ready,
    output o_req_ready, o_bs_data, o_bs_valid, o_bs_id, o_bs_first, o_bs_last, o_busy, o_timeout
  );
endinterface

// File: rtl/backsub_frame_arbiter_rr_arbiter.sv
// rr_arbiter: rotating-priority pick; the search starts one above ptr_i and wraps to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) idx_o = req_i[k] ? IW'(k) : idx_o;
    // lowest requester above the pointer overrides the wrapped-around choice
    for (int k = N - 1; k >= 0; k--) idx_o = (req_i[k] && IW'(k) > ptr_i) ? IW'(k) : idx_o;
    any_o = |req_i;
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/backsub_frame_arbiter.sv
// backsub_frame_arbiter: whole-vector round-robin sharing of one backsub; BACKSUB_ARB_WATCHDOG_EN adds stall watchdog with zero padding.
module backsub_frame_arbiter
  import backsub_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 1024,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 255
) (
  input logic                    i_clock,
  input logic                    i_reset,
  backsub_frame_arbiter_if.slave bus
);
  localparam int IW = id_w(NUM_REQ);
  localparam int CW = $clog2(NUM_WORDS);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IW-1:0]    id;
    logic             first;
    logic             last;
  } word_t;
  if (NUM_WORDS < 2 || NUM_REQ < 2 || TIMEOUT < 1) begin : g_param_check
    $error("backsub_frame_arbiter: NUM_WORDS and NUM_REQ must be >= 2, TIMEOUT >= 1");
  end
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d, g_q, g_d, pick_idx;
  logic [NUM_REQ-1:0] oh_q, oh_d, pick_oh;
  logic [WIDTH-1:0]   sel_data;
  logic               pick_any, xfer, pad_issue, issue, last_w, timeout_d, valid_q, timeout_q;
  word_t              word_q, word_d;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i  (bus.i_req_valid),
    .ptr_i  (ptr_q),
    .grant_o(pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );
  // the backsub has no backpressure, so sink readiness gates the requester directly
  assign bus.o_req_ready = (state_q == STREAM && bus.i_sink_ready) ? oh_q : '0;
  assign xfer = |(bus.i_req_valid & bus.o_req_ready);
  assign issue = xfer || pad_issue;
  assign last_w = cnt_q == CW'(NUM_WORDS - 1);
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) sel_data = oh_q[k] ? bus.i_req_data[k*WIDTH +: WIDTH] : sel_data;
  end
`ifdef BACKSUB_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  assign stall_d = (state_q == STREAM && bus.i_sink_ready && !(|(bus.i_req_valid & oh_q))) ? stall_q + 1'b1 : '0;
  assign timeout_d = stall_d == SW'(TIMEOUT);
  assign pad_issue = state_q == PAD && bus.i_sink_ready;
  always_ff @(posedge i_clock) stall_q <= (i_reset || timeout_d) ? '0 : stall_d;
`else
  assign timeout_d = 1'b0;
  assign pad_issue = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    g_d = g_q;
    oh_d = oh_q;
    word_d = word_q;
    if (state_q == IDLE && pick_any) begin
      state_d = STREAM;
      g_d = pick_idx;
      oh_d = pick_oh;
    end
    if (timeout_d) state_d = PAD;
    if (issue) begin
      word_d = '{data: xfer ? sel_data : {WIDTH{1'b0}}, id: g_q, first: cnt_q == '0, last: last_w};
      cnt_d = last_w ? '0 : cnt_q + 1'b1;
      state_d = last_w ? IDLE : state_d;
      ptr_d = last_w ? g_q : ptr_q;
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= IW'(NUM_REQ - 1);
      g_q <= '0;
      oh_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
      oh_q <= oh_d;
      word_q <= word_d;
      valid_q <= issue;
      timeout_q <= timeout_d;
    end
  end
  assign bus.o_bs_data = word_q.data;
  assign bus.o_bs_id = word_q.id;
  assign bus.o_bs_first = word_q.first;
  assign bus.o_bs_last = word_q.last;
  assign bus.o_bs_valid = valid_q;
  assign bus.o_busy = state_q == STREAM || state_q == PAD;
  assign bus.o_timeout = timeout_q;
endmodule

// File: tb/tb_backsub_frame_arbiter.sv
// tb_backsub_frame_arbiter: directed bench for backsub_frame_arbiter with NUM_REQ=3, NUM_WORDS=4, TIMEOUT=8.
module tb_backsub_frame_arbiter;
  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clock = ~i_clock;
  backsub_frame_arbiter_if #(.WIDTH(8), .NUM_REQ(3)) bus ();
  backsub_frame_arbiter #(.WIDTH(8), .NUM_WORDS(4), .NUM_REQ(3), .TIMEOUT(8)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus    (bus.slave)
  );
  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic [7:0] data;
    logic       first;
    logic       last;
  } rec_t;
  rec_t       mon[$];
  int         cyc = 0;
  logic [7:0] words [3][4];
  int         idx [3];
  int         lim [3];
  logic [2:0] en;
  logic [2:0] rdy;
  logic       sink;
  int         checks = 0;
  int         failures = 0;
  always @(posedge i_clock) cyc <= cyc + 1;
  always @(negedge i_clock)
    if (bus.o_bs_valid === 1'b1)
      mon.push_back('{cyc: cyc, id: bus.o_bs_id, data: bus.o_bs_data, first: bus.o_bs_first, last: bus.o_bs_last});
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask
  task automatic step();
    logic [2:0] hs;
    for (int k = 0; k < 3; k++) begin
      bus.i_req_valid[k] = en[k] && idx[k] < lim[k];
      bus.i_req_data[k*8 +: 8] = words[k][idx[k] % 4];
    end
    bus.i_sink_ready = sink;
    #2;
    rdy = bus.o_req_ready;
    hs = bus.i_req_valid & rdy;
    tick();
    for (int k = 0; k < 3; k++) if (hs[k]) idx[k]++;
  endtask
  task automatic load(input int k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    words[k][0] = a;
    words[k][1] = b;
    words[k][2] = c;
    words[k][3] = d;
  endtask
  task automatic do_reset();
    i_reset = 1'b1;
    en = '0;
    sink = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_data = '0;
    bus.i_sink_ready = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx[k] = 0;
      lim[k] = 4;
    end
    mon.delete();
  endtask
  task automatic test_reset();
    i_reset = 1'b1;
    bus.i_req_valid = 3'b111;
    bus.i_req_data = 24'hFFFFFF;
    bus.i_sink_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.o_busy, bus.o_bs_valid, bus.o_timeout, bus.o_req_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b valid=%b timeout=%b ready=%b, want all 0", bus.o_busy, bus.o_bs_valid, bus.o_timeout, bus.o_req_ready);
    end
    checks++;
    if ({bus.o_bs_data, bus.o_bs_id, bus.o_bs_first, bus.o_bs_last} !== 12'b0) begin
      failures++;
      $display("FAIL reset_word: data=%h id=%0d first=%b last=%b, want 0", bus.o_bs_data, bus.o_bs_id, bus.o_bs_first, bus.o_bs_last);
    end
  endtask
  task automatic test_single();
    logic [7:0] xo [4];
    logic [7:0] acc;
    xo = '{8'h11, 8'h33, 8'h00, 8'h44};
    acc = 8'h00;
    do_reset();
    load(1, 8'h11, 8'h22, 8'h33, 8'h44);
    en = 3'b010;
    for (int c = 0; c < 20 && idx[1] < 4; c++) step();
    repeat (3) step();
    checks++;
    if (mon.size() !== 4) begin
      failures++;
      $display("FAIL single_count: got %0d words, want 4", mon.size());
    end
    for (int i = 0; i < 4 && i < mon.size(); i++) begin
      acc = (mon[i].first ? 8'h00 : acc) ^ mon[i].data;
      checks++;
      if (mon[i].id !== 2'd1 || mon[i].data !== words[1][i] || mon[i].first !== (i == 0) || mon[i].last !== (i == 3)) begin
        failures++;
        $display("FAIL single_word%0d: id=%0d data=%h first=%b last=%b, want id=1 data=%h first=%b last=%b",
                 i, mon[i].id, mon[i].data, mon[i].first, mon[i].last, words[1][i], i == 0, i == 3);
      end
      checks++;
      if (acc !== xo[i]) begin
        failures++;
        $display("FAIL single_xor%0d: got %h want %h", i, acc, xo[i]);
      end
      if (i > 0) begin
        checks++;
        if (mon[i].cyc - mon[i-1].cyc !== 1) begin
          failures++;
          $display("FAIL single_gap%0d: got %0d want 1", i, mon[i].cyc - mon[i-1].cyc);
        end
      end
    end
  endtask
  task automatic test_round_robin();
    logic [1:0] exp_id;
    do_reset();
    load(0, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    load(1, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    load(2, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    lim[0] = 8;
    en = 3'b111;
    for (int c = 0; c < 80 && (idx[0] < 8 || idx[1] < 4 || idx[2] < 4); c++) step();
    repeat (3) step();
    checks++;
    if (mon.size() !== 16) begin
      failures++;
      $display("FAIL rr_count: got %0d words, want 16", mon.size());
    end
    for (int i = 0; i < 16 && i < mon.size(); i++) begin
      exp_id = 2'((i / 4) % 3);
      checks++;
      if (mon[i].id !== exp_id || mon[i].data !== words[exp_id][i%4] || mon[i].first !== (i % 4 == 0) || mon[i].last !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL rr_word%0d: id=%0d data=%h first=%b last=%b, want id=%0d data=%h first=%b last=%b",
                 i, mon[i].id, mon[i].data, mon[i].first, mon[i].last, exp_id, words[exp_id][i%4], i % 4 == 0, i % 4 == 3);
      end
      if (i > 0) begin
        checks++;
        if (mon[i].cyc - mon[i-1].cyc !== ((i % 4 == 0) ? 2 : 1)) begin
          failures++;
          $display("FAIL rr_gap%0d: got %0d want %0d", i, mon[i].cyc - mon[i-1].cyc, (i % 4 == 0) ? 2 : 1);
        end
      end
    end
  endtask
  task automatic test_sink_stall();
    do_reset();
    load(0, 8'h5A, 8'h6B, 8'h7C, 8'h8D);
    en = 3'b001;
    for (int c = 0; c < 20 && idx[0] < 2; c++) step();
    sink = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++;
      if (rdy !== 3'b000) begin
        failures++;
        $display("FAIL stall_ready%0d: got %b want 000", s, rdy);
      end
      checks++;
      if (bus.o_bs_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_valid%0d: got %b want 0", s, bus.o_bs_valid);
      end
    end
    sink = 1'b1;
    for (int c = 0; c < 20 && idx[0] < 4; c++) step();
    repeat (3) step();
    checks++;
    if (mon.size() !== 4) begin
      failures++;
      $display("FAIL stall_count: got %0d words, want 4", mon.size());
    end
    for (int i = 0; i < 4 && i < mon.size(); i++) begin
      checks++;
      if (mon[i].data !== words[0][i] || mon[i].last !== (i == 3) || mon[i].first !== (i == 0)) begin
        failures++;
        $display("FAIL stall_word%0d: data=%h first=%b last=%b, want data=%h first=%b last=%b",
                 i, mon[i].data, mon[i].first, mon[i].last, words[0][i], i == 0, i == 3);
      end
    end
    if (mon.size() >= 3) begin
      checks++;
      if (mon[2].cyc - mon[1].cyc !== 4) begin
        failures++;
        $display("FAIL stall_gap: got %0d want 4", mon[2].cyc - mon[1].cyc);
      end
    end
  endtask
  task automatic test_no_preempt();
    do_reset();
    load(0, 8'h10, 8'h20, 8'h30, 8'h40);
    load(2, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    en = 3'b001;
    for (int c = 0; c < 20 && idx[0] < 2; c++) step();
    en = 3'b101;
    for (int c = 0; c < 40 && idx[2] < 4; c++) step();
    repeat (3) step();
    checks++;
    if (mon.size() !== 8) begin
      failures++;
      $display("FAIL preempt_count: got %0d words, want 8", mon.size());
    end
    for (int i = 0; i < 8 && i < mon.size(); i++) begin
      checks++;
      if (mon[i].id !== ((i < 4) ? 2'd0 : 2'd2) || mon[i].data !== ((i < 4) ? words[0][i] : words[2][i-4])) begin
        failures++;
        $display("FAIL preempt_word%0d: id=%0d data=%h, want id=%0d data=%h",
                 i, mon[i].id, mon[i].data, (i < 4) ? 0 : 2, (i < 4) ? words[0][i] : words[2][i-4]);
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [7:0] xo [4];
    logic [7:0] acc;
    xo = '{8'h01, 8'h03, 8'h07, 8'h0F};
    acc = 8'hFF;
    do_reset();
    load(0, 8'h01, 8'h02, 8'h04, 8'h08);
    en = 3'b001;
    for (int c = 0; c < 20 && idx[0] < 2; c++) step();
    en = 3'b000;
    bus.i_req_valid = '0;
    i_reset = 1'b1;
    tick();
    checks++;
    if ({bus.o_busy, bus.o_bs_valid, bus.o_req_ready, bus.o_bs_data, bus.o_bs_id, bus.o_bs_first, bus.o_bs_last} !== 16'b0) begin
      failures++;
      $display("FAIL midreset_outs: busy=%b valid=%b ready=%b data=%h id=%0d first=%b last=%b, want all 0",
               bus.o_busy, bus.o_bs_valid, bus.o_req_ready, bus.o_bs_data, bus.o_bs_id, bus.o_bs_first, bus.o_bs_last);
    end
    i_reset = 1'b0;
    idx[0] = 0;
    mon.delete();
    en = 3'b001;
    for (int c = 0; c < 20 && idx[0] < 4; c++) step();
    repeat (3) step();
    checks++;
    if (mon.size() !== 4) begin
      failures++;
      $display("FAIL midreset_count: got %0d words, want 4", mon.size());
    end
    for (int i = 0; i < 4 && i < mon.size(); i++) begin
      acc = (mon[i].first ? 8'h00 : acc) ^ mon[i].data;
      checks++;
      if (acc !== xo[i] || mon[i].first !== (i == 0) || mon[i].last !== (i == 3)) begin
        failures++;
        $display("FAIL midreset_word%0d: xor=%h first=%b last=%b, want xor=%h first=%b last=%b",
                 i, acc, mon[i].first, mon[i].last, xo[i], i == 0, i == 3);
      end
    end
  endtask
`ifdef BACKSUB_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    logic [7:0] exp_d;
    do_reset();
    load(1, 8'h55, 8'h66, 8'h77, 8'h88);
    load(0, 8'h90, 8'h91, 8'h92, 8'h93);
    load(2, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    lim[1] = 2;
    en = 3'b010;
    for (int c = 0; c < 20 && idx[1] < 2; c++) step();
    n = 0;
    while (bus.o_timeout !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL wd_delay: timeout after %0d cycles, want 8", n);
    end
    step();
    checks++;
    if (bus.o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_pulse: timeout=%b one cycle later, want 0", bus.o_timeout);
    end
    en = 3'b101;
    for (int c = 0; c < 40 && idx[2] < 4; c++) step();
    repeat (3) step();
    checks++;
    if (mon.size() < 8) begin
      failures++;
      $display("FAIL wd_count: got %0d words, want at least 8", mon.size());
    end
    for (int i = 0; i < 8 && i < mon.size(); i++) begin
      exp_d = (i < 2) ? words[1][i] : (i < 4) ? 8'h00 : words[2][i-4];
      checks++;
      if (mon[i].id !== ((i < 4) ? 2'd1 : 2'd2) || mon[i].data !== exp_d || mon[i].last !== (i % 4 == 3) || mon[i].first !== (i % 4 == 0)) begin
        failures++;
        $display("FAIL wd_word%0d: id=%0d data=%h first=%b last=%b, want id=%0d data=%h first=%b last=%b",
                 i, mon[i].id, mon[i].data, mon[i].first, mon[i].last, (i < 4) ? 1 : 2, exp_d, i % 4 == 0, i % 4 == 3);
      end
    end
  endtask
`else
  task automatic test_stall_forever();
    do_reset();
    load(1, 8'h55, 8'h66, 8'h77, 8'h88);
    lim[1] = 2;
    en = 3'b010;
    for (int c = 0; c < 20 && idx[1] < 2; c++) step();
    repeat (20) step();
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL stuck_state: busy=%b timeout=%b, want busy=1 timeout=0", bus.o_busy, bus.o_timeout);
    end
    checks++;
    if (mon.size() !== 2) begin
      failures++;
      $display("FAIL stuck_count: got %0d words, want 2", mon.size());
    end
  endtask
`endif
  initial begin
    en = '0;
    sink = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_sink_stall();
    test_no_preempt();
    test_reset_mid();
`ifdef BACKSUB_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_stall_forever();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
